// File: rtl/calc_engine_pkg.sv
// Shared opcode and FSM state types for the calculator engine.
package calc_engine_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_XOR = 3'b011,
        OP_MUL = 3'b100,
        OP_DIV = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_ITER = 2'b10
    } state_e;

    // MUL and DIV are the only codes that go through the iterative unit.
    function automatic logic is_iter(input logic [2:0] f);
        return f[2:1] == 2'b10;
    endfunction

endpackage

// File: rtl/calc_muldiv_seq.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
module calc_muldiv_seq #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         mode,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo,
    output logic         dz,
    output logic         fin
);

    localparam int CNT_W = $clog2(W) + 1;

    logic             mode_q;
    logic             run;
    logic             dz_q;
    logic [CNT_W-1:0] cnt;
    logic [2*W-1:0]   prod;
    logic [2*W-1:0]   mcand;
    logic [W-1:0]     mplier;
    logic [W-1:0]     rem;
    logic [W-1:0]     dvd;
    logic [W-1:0]     quo;
    logic [W-1:0]     divisor;
    logic [W:0]       trial;
    logic [W:0]       diff;
    logic             ge;
    logic [W-1:0]     rem_nxt;

    // Iteration 0 is folded into the start edge so the last of the W steps lands at start+W-1.
    always_comb begin
        divisor = start ? b : quo_div_src();
        trial   = start ? {{W{1'b0}}, a[W-1]} : {rem, dvd[W-1]};
        diff    = trial - {1'b0, divisor};
        ge      = trial >= {1'b0, divisor};
        rem_nxt = ge ? diff[W-1:0] : trial[W-1:0];
    end

    logic [W-1:0] b_q;

    function automatic logic [W-1:0] quo_div_src();
        return b_q;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= 1'b0;
            run    <= 1'b0;
            dz_q   <= 1'b0;
            fin    <= 1'b0;
            cnt    <= '0;
            prod   <= '0;
            mcand  <= '0;
            mplier <= '0;
            rem    <= '0;
            dvd    <= '0;
            quo    <= '0;
            b_q    <= '0;
        end else begin
            fin <= 1'b0;
            if (start) begin
                mode_q <= mode;
                dz_q   <= (b == '0);
                b_q    <= b;
                run    <= 1'b1;
                cnt    <= CNT_W'(1);
                prod   <= b[0] ? {{W{1'b0}}, a} : '0;
                mcand  <= {{W{1'b0}}, a} << 1;
                mplier <= b >> 1;
                rem    <= rem_nxt;
                dvd    <= a << 1;
                quo    <= {{(W-1){1'b0}}, ge};
            end else if (run) begin
                if (mplier[0]) begin
                    prod <= prod + mcand;
                end
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                rem    <= rem_nxt;
                dvd    <= dvd << 1;
                quo    <= {quo[W-2:0], ge};
                cnt    <= cnt + 1'b1;
                if (cnt == CNT_W'(W-1)) begin
                    run <= 1'b0;
                    fin <= 1'b1;
                end
            end
        end
    end

    // With a zero divisor every trial succeeds, leaving quotient all-ones and remainder = dividend.
    always_comb begin
        hi = mode_q ? rem : prod[2*W-1:W];
        lo = mode_q ? quo : prod[W-1:0];
        dz = mode_q & dz_q;
    end

endmodule

// File: rtl/calc_engine.sv
// Calculator core: go edge-detect, control FSM, single-cycle ALU and registered results.
module calc_engine
    import calc_engine_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         go,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [2:0]   f,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [W-1:0] out_h,
    output logic [W-1:0] out_l
);

    localparam logic [W:0] TWO_W = (W+1)'(2*W);
    localparam logic [W:0] ONE_W = (W+1)'(W);

    state_e       state;
    logic         go_q;
    logic         start;
    logic [W-1:0] x_q;
    logic [W-1:0] y_q;
    op_e          f_q;
    logic [W-1:0] alu_h;
    logic [W-1:0] alu_l;
    logic [W:0]   sum;
    logic [2*W-1:0] shl;
    logic [W-1:0] md_hi;
    logic [W-1:0] md_lo;
    logic         md_dz;
    logic         md_fin;

    assign start = go & ~go_q & (state == S_IDLE);

    always_comb begin
        alu_h = '0;
        alu_l = '0;
        sum   = {1'b0, x_q} + {1'b0, y_q};
        shl   = {{W{1'b0}}, x_q} << y_q;
        case (f_q)
            OP_ADD: begin
                alu_l = sum[W-1:0];
                alu_h = {{(W-1){1'b0}}, sum[W]};
            end
            OP_SUB: begin
                alu_l = x_q - y_q;
                alu_h = (x_q < y_q) ? '1 : '0;
            end
            OP_AND: alu_l = x_q & y_q;
            OP_XOR: alu_l = x_q ^ y_q;
            OP_SHL: begin
                if ({1'b0, y_q} < TWO_W) begin
                    alu_h = shl[2*W-1:W];
                    alu_l = shl[W-1:0];
                end
            end
            OP_SHR: begin
                if ({1'b0, y_q} < ONE_W) begin
                    alu_l = x_q >> y_q;
                end
            end
            default: begin
                alu_h = '0;
                alu_l = '0;
            end
        endcase
    end

    // Raw operands feed the iterative unit so its first step happens on the start edge itself.
    calc_muldiv_seq #(.W(W)) u_muldiv (
        .clk   (clk),
        .rst   (rst),
        .start (start & is_iter(f)),
        .mode  (f[0]),
        .a     (x),
        .b     (y),
        .hi    (md_hi),
        .lo    (md_lo),
        .dz    (md_dz),
        .fin   (md_fin)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            go_q  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            out_h <= '0;
            out_l <= '0;
            x_q   <= '0;
            y_q   <= '0;
            f_q   <= OP_ADD;
        end else begin
            go_q <= go;
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        x_q   <= x;
                        y_q   <= y;
                        f_q   <= op_e'(f);
                        err   <= 1'b0;
                        busy  <= 1'b1;
                        state <= is_iter(f) ? S_ITER : S_EXEC;
                    end
                end
                S_EXEC: begin
                    out_h <= alu_h;
                    out_l <= alu_l;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                S_ITER: begin
                    if (md_fin) begin
                        out_h <= md_hi;
                        out_l <= md_lo;
                        err   <= md_dz;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_engine.sv
// Directed-vector and random-model bench for calc_engine at W=4 and W=8.
module tb_calc_engine;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       go4 = 1'b0;
    logic [3:0] x4 = '0, y4 = '0;
    logic [2:0] f4 = '0;
    logic       busy4, done4, err4;
    logic [3:0] h4, l4;

    logic       go8 = 1'b0;
    logic [7:0] x8 = '0, y8 = '0;
    logic [2:0] f8 = '0;
    logic       busy8, done8, err8;
    logic [7:0] h8, l8;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    calc_engine #(.W(4)) dut4 (
        .clk(clk), .rst(rst), .go(go4), .x(x4), .y(y4), .f(f4),
        .busy(busy4), .done(done4), .err(err4), .out_h(h4), .out_l(l4)
    );

    calc_engine #(.W(8)) dut8 (
        .clk(clk), .rst(rst), .go(go8), .x(x8), .y(y8), .f(f8),
        .busy(busy8), .done(done8), .err(err8), .out_h(h8), .out_l(l8)
    );

    typedef struct {
        logic [3:0] x;
        logic [3:0] y;
        logic [2:0] f;
        logic [3:0] eh;
        logic [3:0] el;
        logic       ee;
        int         lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One operation on the W=4 instance; latency counted in edges after the start edge.
    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic [2:0] fn,
                       output logic bsy, output int lat, output logic unstable, output logic dn2);
        logic [3:0] ph, pl;
        @(negedge clk);
        x4 = a; y4 = b; f4 = fn; go4 = 1'b1;
        ph = h4; pl = l4;
        @(posedge clk); #1;
        go4 = 1'b0;
        bsy = busy4;
        lat = 0;
        unstable = 1'b0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (done4) break;
            if (h4 !== ph || l4 !== pl || busy4 !== 1'b1) unstable = 1'b1;
        end
        if (busy4 !== 1'b0) unstable = 1'b1;
        @(posedge clk); #1;
        dn2 = done4;
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [2:0] fn,
                       output int lat);
        @(negedge clk);
        x8 = a; y8 = b; f8 = fn; go8 = 1'b1;
        @(posedge clk); #1;
        go8 = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (done8) break;
        end
    endtask

    function automatic logic [8:0] model4(input logic [3:0] a, input logic [3:0] b, input logic [2:0] fn);
        logic [7:0] r;
        logic e;
        e = 1'b0;
        case (fn)
            3'd0: r = {4'b0, a} + {4'b0, b};
            3'd1: r = {4'b0, a} - {4'b0, b};
            3'd2: r = {4'b0, a & b};
            3'd3: r = {4'b0, a ^ b};
            3'd4: r = {4'b0, a} * {4'b0, b};
            3'd5: begin
                if (b == 4'd0) begin r = {a, 4'hF}; e = 1'b1; end
                else r = {a % b, a / b};
            end
            3'd6: r = (b >= 4'd8) ? 8'h00 : ({4'b0, a} << b);
            default: r = (b >= 4'd4) ? 8'h00 : {4'b0, a >> b};
        endcase
        return {e, r};
    endfunction

    vec_t vecs [0:16];

    initial begin
        logic bsy, unst, dn2;
        int lat, cnt;
        logic [8:0] m;

        vecs[0]  = '{4'hF, 4'h1, 3'd0, 4'h1, 4'h0, 1'b0, 1};
        vecs[1]  = '{4'h3, 4'h5, 3'd1, 4'hF, 4'hE, 1'b0, 1};
        vecs[2]  = '{4'hF, 4'hF, 3'd4, 4'hE, 4'h1, 1'b0, 4};
        vecs[3]  = '{4'hD, 4'h4, 3'd5, 4'h1, 4'h3, 1'b0, 4};
        vecs[4]  = '{4'h9, 4'h0, 3'd5, 4'h9, 4'hF, 1'b1, 4};
        vecs[5]  = '{4'hC, 4'hA, 3'd2, 4'h0, 4'h8, 1'b0, 1};
        vecs[6]  = '{4'hC, 4'hA, 3'd3, 4'h0, 4'h6, 1'b0, 1};
        vecs[7]  = '{4'h3, 4'h2, 3'd6, 4'h0, 4'hC, 1'b0, 1};
        vecs[8]  = '{4'hF, 4'h6, 3'd6, 4'hC, 4'h0, 1'b0, 1};
        vecs[9]  = '{4'hF, 4'h8, 3'd6, 4'h0, 4'h0, 1'b0, 1};
        vecs[10] = '{4'hC, 4'h2, 3'd7, 4'h0, 4'h3, 1'b0, 1};
        vecs[11] = '{4'hC, 4'h4, 3'd7, 4'h0, 4'h0, 1'b0, 1};
        vecs[12] = '{4'h7, 4'h8, 3'd0, 4'h0, 4'hF, 1'b0, 1};
        vecs[13] = '{4'h5, 4'h5, 3'd1, 4'h0, 4'h0, 1'b0, 1};
        vecs[14] = '{4'hF, 4'hF, 3'd5, 4'h0, 4'h1, 1'b0, 4};
        vecs[15] = '{4'h0, 4'h7, 3'd4, 4'h0, 4'h0, 1'b0, 4};
        vecs[16] = '{4'hF, 4'h3, 3'd7, 4'h0, 4'h1, 1'b0, 1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'b0, busy4}, 0);
        chk("rst_done", {31'b0, done4}, 0);
        chk("rst_err",  {31'b0, err4},  0);
        chk("rst_out",  {24'b0, h4, l4}, 0);
        chk("rst_out8", {16'b0, h8, l8}, 0);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            op4(vecs[i].x, vecs[i].y, vecs[i].f, bsy, lat, unst, dn2);
            chk($sformatf("v%0d_busy", i), {31'b0, bsy}, 1);
            chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_h", i), {28'b0, h4}, {28'b0, vecs[i].eh});
            chk($sformatf("v%0d_l", i), {28'b0, l4}, {28'b0, vecs[i].el});
            chk($sformatf("v%0d_err", i), {31'b0, err4}, {31'b0, vecs[i].ee});
            chk($sformatf("v%0d_stable", i), {31'b0, unst}, 0);
            chk($sformatf("v%0d_pulse", i), {31'b0, dn2}, 0);
        end

        // go held high for 20 cycles must start exactly one MUL.
        @(negedge clk);
        x4 = 4'h3; y4 = 4'h5; f4 = 3'd4; go4 = 1'b1;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (done4) cnt++;
        end
        go4 = 1'b0;
        chk("held_one_done", cnt, 1);
        chk("held_result", {24'b0, h4, l4}, 32'h0F);

        // A second rising edge while busy is dropped.
        cnt = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            x4 = 4'h2; y4 = 4'h7; f4 = 3'd4;
            go4 = (c == 0 || c == 2);
            @(posedge clk); #1;
            if (done4) cnt++;
        end
        go4 = 1'b0;
        chk("edge_busy_one_done", cnt, 1);
        chk("edge_busy_result", {24'b0, h4, l4}, 32'h0E);

        // Reset two cycles into a MUL aborts it.
        @(negedge clk);
        x4 = 4'hF; y4 = 4'hF; f4 = 3'd4; go4 = 1'b1;
        @(posedge clk);
        @(negedge clk); go4 = 1'b0;
        @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", {31'b0, busy4}, 0);
        chk("abort_out", {24'b0, h4, l4}, 0);
        @(negedge clk); rst = 1'b0;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (done4) cnt++;
        end
        chk("abort_no_done", cnt, 0);
        op4(4'h2, 4'h3, 3'd0, bsy, lat, unst, dn2);
        chk("after_abort_add", {24'b0, h4, l4}, 32'h05);

        // rst and go together: reset wins.
        @(negedge clk); rst = 1'b1; go4 = 1'b1;
        @(posedge clk); #1;
        chk("rst_go_busy", {31'b0, busy4}, 0);
        @(negedge clk); rst = 1'b0; go4 = 1'b0;
        @(posedge clk); #1;
        chk("rst_go_idle", {31'b0, busy4}, 0);

        op8(8'hFF, 8'hFF, 3'd4, lat);
        chk("w8_mul_lat", lat, 8);
        chk("w8_mul", {16'b0, h8, l8}, 32'hFE01);
        op8(8'h81, 8'h09, 3'd6, lat);
        chk("w8_shl_lat", lat, 1);
        chk("w8_shl", {16'b0, h8, l8}, 32'h0200);
        op8(8'd200, 8'd7, 3'd5, lat);
        chk("w8_div_lat", lat, 8);
        chk("w8_div", {15'b0, err8, h8, l8}, 32'h041C);

        for (int n = 0; n < 200; n++) begin
            logic [3:0] ra, rb;
            logic [2:0] rf;
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rf = 3'($urandom_range(0, 7));
            m = model4(ra, rb, rf);
            op4(ra, rb, rf, bsy, lat, unst, dn2);
            chk($sformatf("r%0d_lat", n), lat, (rf[2:1] == 2'b10) ? 4 : 1);
            chk($sformatf("r%0d_res", n), {23'b0, err4, h4, l4}, {23'b0, m});
            chk($sformatf("r%0d_stable", n), {31'b0, unst}, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
